rsc_vit_dec: RTL and testbench
==============================

RSC_VIT_DEC -- requirements
Module: rsc_vit_dec

Interface
REQ-001 Parameter BLK_LEN, default 4, number of information bits per decoded block.
REQ-002 Parameter PM_W, default 4, path-metric width in bits.
REQ-003 clk  input  1  single system clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 dec_en  input  1  symbol valid; sys_in/par_in are sampled on a rising clk edge only when dec_en=1 and busy=0.
REQ-006 sys_in  input  1  received systematic bit, hard decision.
REQ-007 par_in  input  1  received parity bit, hard decision.
REQ-008 dec_out  output  BLK_LEN  decoded block; first received info bit is in dec_out[BLK_LEN-1] (MSB-first).
REQ-009 dec_over  output  1  one-cycle pulse; it is high in the first cycle in which dec_out holds a new block.
REQ-010 busy  output  1  high during traceback; symbols presented while busy=1 are ignored.

Function
REQ-011 The decoded code is the memory-2 RSC code: state (s1,s2) starts at 0; a = u^s1^s2; parity = a^s2; systematic = u; next state = (a,s1).
REQ-012 Each block is unterminated, starts in state 0, and consists of BLK_LEN symbol pairs.
REQ-013 Decoding is a 4-state hard-decision Viterbi decoder.
REQ-014 The branch metric is the Hamming distance (0..2) between the received pair and the branch output pair.
REQ-015 At block start, path metrics are state0=0 and states1..3=7.
REQ-016 Path metrics are unsigned PM_W bits and saturate at all-ones; no normalization is performed.
REQ-017 ACS runs one step per accepted symbol and completes in the same cycle the symbol is accepted.
REQ-018 Each next state (a,s1) has two predecessors (s1,0) and (s1,1); the decision bit records the chosen s2.
REQ-019 On an ACS tie, the predecessor with s2=0 is selected.
REQ-020 The survivor memory is BLK_LEN x 4 decision bits.
REQ-021 FSM states and transitions:
- IDLE: on the first accepted symbol, go to ACS.
- ACS: when the BLK_LEN-th symbol is accepted, go to TB.
- TB: BLK_LEN cycles, one traceback step per cycle, starting from the minimum-metric final state (tie -> lowest state index); then go to OUT.
- OUT: one cycle; go to IDLE.
REQ-022 Recovered information bit u = a^s1^s2, taken from the current and predecessor states.
REQ-023 busy=1 exactly while in TB.
REQ-024 Latency: dec_over rises BLK_LEN+1 cycles after the edge that accepts the last symbol.
REQ-025 dec_out holds its value until the next dec_over.
REQ-026 A symbol accepted in OUT or IDLE starts a new block with reinitialised metrics; back-to-back blocks lose no symbol.
REQ-027 dec_en=0 in ACS stalls the decoder with no state change; there is no timeout.

Reset
REQ-028 rst=1 asynchronously forces: FSM=IDLE, dec_out=0, dec_over=0, busy=0, symbol counter=0, metrics to their initial values.
REQ-029 rst asserted mid-block or mid-traceback aborts the block without emitting dec_over; decoding restarts with the first symbol accepted after rst deasserts.

Structure
REQ-030 A shared package holds the FSM state encoding, the trellis next-state/output functions, and the metric initial constants.
REQ-031 One sub-module, rsc_acs, implements a single add-compare-select butterfly and is instantiated twice.

Verification
REQ-032 Error-free block: symbols (1,1),(0,1),(1,0),(1,0) -> dec_out=4'b1011, dec_over pulse 5 cycles after the last symbol.
REQ-033 All-zero block: four (0,0) symbols -> dec_out=4'b0000, with a single dec_over pulse.
REQ-034 Single parity error: symbols (1,1),(0,0),(1,0),(1,0) -> dec_out=4'b1011.
REQ-035 Back-to-back blocks: 1011 then 0000 presented with dec_en held high, including symbols offered while busy -> two correct blocks; symbols offered during busy are dropped.
REQ-036 Abort: rst pulsed after 2 symbols, then the full 1011 block -> no dec_over before the reset; dec_out=4'b1011 afterwards.
REQ-037 Stall: dec_en low for 3 cycles between symbols 2 and 3 of block 1011 -> dec_out=4'b1011, with latency counted from the last symbol.

Source files
------------

// File: rtl/rsc_vit_dec_pkg.sv
// Shared definitions for the memory-2 RSC hard-decision Viterbi decoder:
// FSM encoding, trellis functions and path-metric start values.
package rsc_vit_dec_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACS  = 2'd1;
  localparam logic [1:0] ST_TB   = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  localparam int PM_INIT_ZERO  = 0;
  localparam int PM_INIT_OTHER = 7;

  // State is {s1,s2}; feedback bit a = u^s1^s2 becomes the new s1.
  function automatic logic [1:0] rsc_next(input logic [1:0] st, input logic u);
    logic a;
    a = u ^ st[1] ^ st[0];
    return {a, st[1]};
  endfunction

  // Branch output pair {systematic, parity}.
  function automatic logic [1:0] rsc_out(input logic [1:0] st, input logic u);
    logic a;
    a = u ^ st[1] ^ st[0];
    return {u, a ^ st[0]};
  endfunction

endpackage

// File: rtl/rsc_acs.sv
// One add-compare-select butterfly: predecessors (S1,0),(S1,1) feed
// next states (0,S1) and (1,S1).
module rsc_acs
  import rsc_vit_dec_pkg::*;
#(
  parameter int   PM_W = 4,
  parameter logic S1   = 1'b0
) (
  input  logic [PM_W-1:0] pm_pred0,
  input  logic [PM_W-1:0] pm_pred1,
  input  logic            sys_in,
  input  logic            par_in,
  output logic [PM_W-1:0] pm_next0,
  output logic [PM_W-1:0] pm_next1,
  output logic            dec0,
  output logic            dec1
);

  function automatic logic [1:0] hamming(input logic [1:0] rx, input logic [1:0] ex);
    logic [1:0] d;
    d = rx ^ ex;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm, input logic [1:0] bm);
    logic [PM_W:0] sum;
    sum = {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
    return sum[PM_W] ? {PM_W{1'b1}} : sum[PM_W-1:0];
  endfunction

  // Returns {decision, metric}; ties keep the s2=0 predecessor.
  function automatic logic [PM_W:0] acs(input logic a, input logic [PM_W-1:0] p0,
                                        input logic [PM_W-1:0] p1, input logic [1:0] rx);
    logic [PM_W-1:0] m0;
    logic [PM_W-1:0] m1;
    m0 = sat_add(p0, hamming(rx, rsc_out({S1, 1'b0}, a ^ S1)));
    m1 = sat_add(p1, hamming(rx, rsc_out({S1, 1'b1}, a ^ S1 ^ 1'b1)));
    return (m1 < m0) ? {1'b1, m1} : {1'b0, m0};
  endfunction

  assign {dec0, pm_next0} = acs(1'b0, pm_pred0, pm_pred1, {sys_in, par_in});
  assign {dec1, pm_next1} = acs(1'b1, pm_pred0, pm_pred1, {sys_in, par_in});

endmodule

// File: rtl/rsc_vit_dec.sv
// Block-wise 4-state hard-decision Viterbi decoder for the memory-2 RSC code,
// one ACS step per accepted symbol followed by a BLK_LEN-cycle traceback.
module rsc_vit_dec
  import rsc_vit_dec_pkg::*;
#(
  parameter int BLK_LEN = 4,
  parameter int PM_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_en,
  input  logic               sys_in,
  input  logic               par_in,
  output logic [BLK_LEN-1:0] dec_out,
  output logic               dec_over,
  output logic               busy
);

  localparam int CNT_W = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
  localparam logic [3:0][PM_W-1:0] PM_INIT = {PM_W'(PM_INIT_OTHER), PM_W'(PM_INIT_OTHER),
                                              PM_W'(PM_INIT_OTHER), PM_W'(PM_INIT_ZERO)};

  logic [1:0]               state;
  logic [CNT_W-1:0]         cnt;
  logic [3:0][PM_W-1:0]     pm;
  logic [3:0][PM_W-1:0]     pm_src;
  logic [3:0][PM_W-1:0]     pm_acs;
  logic [3:0]               dec_acs;
  logic [BLK_LEN-1:0][3:0]  surv;
  logic [1:0]               tb_state;
  logic [CNT_W-1:0]         tb_t;
  logic [BLK_LEN-1:0]       tb_bits;
  logic                     accept;
  logic                     last;
  logic [CNT_W-1:0]         cnt_eff;
  logic                     tb_dec;

  function automatic logic [1:0] min_state(input logic [3:0][PM_W-1:0] m);
    logic [1:0] best;
    best = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (m[i] < m[best]) best = 2'(i);
    end
    return best;
  endfunction

  assign busy    = (state == ST_TB);
  assign accept  = dec_en && !busy;
  // Any symbol accepted outside ACS opens a fresh block from the start metrics.
  assign pm_src  = (state == ST_ACS) ? pm : PM_INIT;
  assign cnt_eff = (state == ST_ACS) ? cnt : '0;
  assign last    = (cnt_eff == CNT_W'(BLK_LEN - 1));
  assign tb_dec  = surv[tb_t][tb_state];

  rsc_acs #(.PM_W(PM_W), .S1(1'b0)) u_acs0 (
    .pm_pred0 (pm_src[0]),
    .pm_pred1 (pm_src[1]),
    .sys_in   (sys_in),
    .par_in   (par_in),
    .pm_next0 (pm_acs[0]),
    .pm_next1 (pm_acs[2]),
    .dec0     (dec_acs[0]),
    .dec1     (dec_acs[2])
  );

  rsc_acs #(.PM_W(PM_W), .S1(1'b1)) u_acs1 (
    .pm_pred0 (pm_src[2]),
    .pm_pred1 (pm_src[3]),
    .sys_in   (sys_in),
    .par_in   (par_in),
    .pm_next0 (pm_acs[1]),
    .pm_next1 (pm_acs[3]),
    .dec0     (dec_acs[1]),
    .dec1     (dec_acs[3])
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      pm       <= PM_INIT;
      dec_out  <= '0;
      dec_over <= 1'b0;
    end else begin
      dec_over <= 1'b0;
      case (state)
        ST_IDLE, ST_OUT: begin
          if (state == ST_OUT) begin
            dec_out  <= tb_bits;
            dec_over <= 1'b1;
          end
          if (accept) begin
            pm    <= pm_acs;
            cnt   <= last ? '0 : CNT_W'(1);
            state <= last ? ST_TB : ST_ACS;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACS: begin
          if (accept) begin
            pm <= pm_acs;
            if (last) begin
              cnt   <= '0;
              state <= ST_TB;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          if (tb_t == '0) state <= ST_OUT;
        end
      endcase
    end
  end

  // Survivor memory and traceback datapath.
  always_ff @(posedge clk) begin
    if (accept) begin
      surv[cnt_eff] <= dec_acs;
      if (last) begin
        tb_state <= min_state(pm_acs);
        tb_t     <= CNT_W'(BLK_LEN - 1);
      end
    end
    if (busy) begin
      tb_bits  <= BLK_LEN'({tb_state[1] ^ tb_state[0] ^ tb_dec, tb_bits} >> 1);
      tb_state <= {tb_state[0], tb_dec};
      tb_t     <= tb_t - 1'b1;
    end
  end

endmodule

// File: tb/tb_rsc_vit_dec.sv
// Directed bench for rsc_vit_dec: table of hand-decoded blocks plus
// back-to-back, abort and stall sequences.
module tb_rsc_vit_dec;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_en;
  logic       sys_in;
  logic       par_in;
  logic [3:0] dec_out;
  logic       dec_over;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int over_cnt = 0;

  typedef struct {
    string      name;
    logic [3:0] sys;
    logic [3:0] par;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[5];

  rsc_vit_dec #(.BLK_LEN(4), .PM_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .dec_en   (dec_en),
    .sys_in   (sys_in),
    .par_in   (par_in),
    .dec_out  (dec_out),
    .dec_over (dec_over),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dec_over === 1'b1) over_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic s, input logic p);
    int guard = 0;
    while (busy && guard < 50) begin
      tick();
      guard++;
    end
    dec_en = 1'b1;
    sys_in = s;
    par_in = p;
    tick();
    dec_en = 1'b0;
  endtask

  task automatic send_range(input logic [3:0] s, input logic [3:0] p, input int from, input int upto);
    for (int i = from; i < upto; i++) send_sym(s[3-i], p[3-i]);
  endtask

  // Called one step after the edge that accepted the last symbol.
  task automatic wait_result(input string name, input logic [3:0] exp);
    int  n = 0;
    bit  got = 0;
    logic [3:0] held;
    check({name, " busy"}, {31'd0, busy}, 32'd1);
    while (n < 20 && !got) begin
      tick();
      n++;
      if (dec_over) got = 1;
    end
    check({name, " latency"}, got ? n : -1, 32'd5);
    check({name, " dec_out"}, {28'd0, dec_out}, {28'd0, exp});
    held = dec_out;
    tick();
    check({name, " pulse_width"}, {31'd0, dec_over}, 32'd0);
    check({name, " hold"}, {28'd0, dec_out}, {28'd0, held});
  endtask

  initial begin
    bit   bsys[8] = '{1, 0, 1, 1, 0, 0, 0, 0};
    bit   bpar[8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    logic [3:0] cap[2];
    int   idx, caps, snap;
    bit   take;

    vecs[0] = '{"clean_1011",  4'b1011, 4'b1100, 4'b1011};
    vecs[1] = '{"zero_0000",   4'b0000, 4'b0000, 4'b0000};
    vecs[2] = '{"parerr_1011", 4'b1011, 4'b1000, 4'b1011};
    vecs[3] = '{"clean_0110",  4'b0110, 4'b0100, 4'b0110};
    vecs[4] = '{"clean_1111",  4'b1111, 4'b1011, 4'b1111};

    rst = 1'b1; dec_en = 1'b0; sys_in = 1'b0; par_in = 1'b0;
    tick(); tick();
    check("reset dec_out", {28'd0, dec_out}, 32'd0);
    check("reset dec_over", {31'd0, dec_over}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      send_range(vecs[i].sys, vecs[i].par, 0, 4);
      wait_result(vecs[i].name, vecs[i].exp);
      tick();
    end

    // Back-to-back blocks with dec_en held high; garbage offered while busy.
    idx = 0; caps = 0;
    for (int c = 0; c < 60 && caps < 2; c++) begin
      dec_en = (idx < 8);
      if (idx < 8 && !busy) begin
        sys_in = bsys[idx]; par_in = bpar[idx]; take = 1;
      end else begin
        sys_in = 1'b1; par_in = 1'b1; take = 0;
      end
      tick();
      if (take) idx++;
      if (dec_over) begin
        cap[caps] = dec_out;
        caps++;
      end
    end
    dec_en = 1'b0;
    check("b2b blocks", caps, 32'd2);
    check("b2b first", {28'd0, cap[0]}, 32'hB);
    check("b2b second", {28'd0, cap[1]}, 32'h0);
    tick(); tick();

    // Abort mid-block: two symbols, reset, then the full block.
    snap = over_cnt;
    send_range(4'b1011, 4'b1100, 0, 2);
    #1 rst = 1'b1;
    #1;
    check("abort dec_out cleared", {28'd0, dec_out}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("abort no dec_over", over_cnt, snap);
    send_range(4'b1011, 4'b1100, 0, 4);
    wait_result("abort_then_1011", 4'b1011);

    // Abort mid-traceback must not emit a block.
    snap = over_cnt;
    send_range(4'b0000, 4'b0000, 0, 4);
    tick();
    check("tb_abort busy before", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("tb_abort busy after", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("tb_abort no dec_over", over_cnt, snap);
    check("tb_abort dec_out", {28'd0, dec_out}, 32'd0);

    // Stall of three cycles between symbols 2 and 3.
    send_range(4'b1011, 4'b1100, 0, 2);
    tick(); tick(); tick();
    check("stall busy", {31'd0, busy}, 32'd0);
    send_range(4'b1011, 4'b1100, 2, 4);
    wait_result("stall_1011", 4'b1011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
